// File: rtl/riscv_pkg.sv
// Shared core types and constants for the RV32I multi-cycle core.
// Holds the fetch-sequencer state encoding and next-PC source selectors.
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BR   = 2'd1,
        PC_JAL  = 2'd2,
        PC_JALR = 2'd3
    } pc_src_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Only bit 1 matters: bit 0 is either cleared (JALR) or never checked.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1];
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_gen.sv
// Combinational next-PC selection: jalr > jump > branch > sequential.
// Flags a redirect whose target is not word aligned.
module next_pc_gen
    import riscv_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    input  logic        i_branch_taken,
    input  logic        i_jump,
    input  logic        i_jalr,
    output logic [31:0] o_next_pc,
    output pc_src_t     o_pc_src,
    output logic        o_misaligned
);

    logic [31:0] w_seq_tgt;
    logic [31:0] w_rel_tgt;
    logic [31:0] w_jalr_tgt;

    assign w_seq_tgt  = i_pc + INSTR_BYTES;
    assign w_rel_tgt  = i_pc + i_imm;
    assign w_jalr_tgt = (i_rs1 + i_imm) & ~32'd1;

    always_comb begin
        o_pc_src = PC_SEQ;
        if (i_jalr)
            o_pc_src = PC_JALR;
        else if (i_jump)
            o_pc_src = PC_JAL;
        else if (i_branch_taken)
            o_pc_src = PC_BR;
    end

    always_comb begin
        o_next_pc = w_seq_tgt;
        case (o_pc_src)
            PC_JALR: o_next_pc = w_jalr_tgt;
            PC_JAL:  o_next_pc = w_rel_tgt;
            PC_BR:   o_next_pc = w_rel_tgt;
            default: o_next_pc = w_seq_tgt;
        endcase
    end

    assign o_misaligned = (o_pc_src != PC_SEQ) && is_misaligned(o_next_pc);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and one-at-a-time fetch sequencer (BOOT -> FETCH -> EXEC).
// Retires on EXEC with stall low; misaligned redirects vector to TRAP_VEC.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        trap,
    output logic [63:0] instret
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [63:0] r_instret;

    logic        w_in_exec;
    logic        w_retire;
    logic        w_trap;
    logic [31:0] w_next_pc;
    pc_src_t     w_pc_src;
    logic        w_misaligned;
    logic [31:0] w_pc_load;

    assign w_in_exec = (r_state == EXEC);

    // Control inputs are gated so nothing outside EXEC can steer the PC.
    next_pc_gen u_next_pc_gen (
        .i_pc           (r_pc),
        .i_imm          (imm),
        .i_rs1          (rs1),
        .i_branch_taken (w_in_exec & branch_taken),
        .i_jump         (w_in_exec & jump),
        .i_jalr         (w_in_exec & jalr),
        .o_next_pc      (w_next_pc),
        .o_pc_src       (w_pc_src),
        .o_misaligned   (w_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= BOOT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        inst_valid  = 1'b0;
        w_retire    = 1'b0;
        w_trap      = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready)
                    w_state_nxt = EXEC;
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    w_retire    = 1'b1;
                    w_trap      = w_misaligned && (w_pc_src != PC_SEQ);
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign w_pc_load = w_trap ? TRAP_VEC : w_next_pc;

    // pc_plus4 is kept as its own register so the link value never ripples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + INSTR_BYTES;
            r_instret  <= 64'd0;
        end else if (w_retire) begin
            r_pc       <= w_pc_load;
            r_pc_plus4 <= w_pc_load + INSTR_BYTES;
            r_instret  <= r_instret + 64'd1;
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign pc_plus4  = r_pc_plus4;
    assign instret   = r_instret;
    assign trap      = w_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: a driver pushes expected retire results,
// a monitor pops them when the DUT retires an instruction.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1 = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        trap;
    logic [63:0] instret;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_ready   (imem_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jalr         (jalr),
        .imm          (imm),
        .rs1          (rs1),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .inst_valid   (inst_valid),
        .trap         (trap),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        trap;
        logic [63:0] instret;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = 32'h0;
    logic [63:0] m_instret = 64'd0;

    exp_t        mon_e;
    logic        mon_trap;

    // Retire monitor: trap sampled in the retiring cycle, pc/instret after the edge.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0 && inst_valid === 1'b1 && stall === 1'b0) begin
            mon_trap = trap;
            @(posedge clk);
            #1;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected got pc %h exp no retire", pc);
            end else begin
                mon_e = sb_q.pop_front();
                checks++;
                if (pc !== mon_e.pc) begin
                    errors++;
                    $display("FAIL retire_pc got %h exp %h", pc, mon_e.pc);
                end
                checks++;
                if (mon_trap !== mon_e.trap) begin
                    errors++;
                    $display("FAIL retire_trap got %b exp %b (pc %h)", mon_trap, mon_e.trap, mon_e.pc);
                end
                checks++;
                if (instret !== mon_e.instret) begin
                    errors++;
                    $display("FAIL retire_instret got %0d exp %0d", instret, mon_e.instret);
                end
                checks++;
                if (pc_plus4 !== mon_e.pc + 32'd4) begin
                    errors++;
                    $display("FAIL retire_pc_plus4 got %h exp %h", pc_plus4, mon_e.pc + 32'd4);
                end
                checks++;
                if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL retire_to_fetch got req %b valid %b exp req 1 valid 0", imem_req, inst_valid);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in FETCH; returns with the DUT back in FETCH.
    task automatic exec_instr(input int rdy_wait, input int stall_n,
                              input logic br, input logic j, input logic jr,
                              input logic [31:0] imm_v, input logic [31:0] rs1_v);
        logic [31:0] tgt;
        logic        redir;
        exp_t        e;
        for (int w = 0; w < rdy_wait; w++) begin
            imem_ready   = 1'b0;
            branch_taken = 1'($urandom_range(0, 1));
            jump         = 1'($urandom_range(0, 1));
            jalr         = 1'($urandom_range(0, 1));
            imm          = $urandom;
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || pc !== m_pc || inst_valid !== 1'b0 || trap !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait got req %b addr %h pc %h valid %b trap %b exp req 1 addr %h valid 0 trap 0",
                         imem_req, imem_addr, pc, inst_valid, trap, m_pc);
            end
            tick();
        end
        imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            errors++;
            $display("FAIL fetch_addr got req %b addr %h exp req 1 addr %h", imem_req, imem_addr, m_pc);
        end
        tick();
        imem_ready   = 1'b0;
        branch_taken = br;
        jump         = j;
        jalr         = jr;
        imm          = imm_v;
        rs1          = rs1_v;
        for (int s = 0; s < stall_n; s++) begin
            stall      = 1'b1;
            imem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (inst_valid !== 1'b1 || imem_req !== 1'b0 || trap !== 1'b0 || pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
                errors++;
                $display("FAIL exec_stall got valid %b req %b trap %b pc %h pc4 %h exp valid 1 req 0 trap 0 pc %h pc4 %h",
                         inst_valid, imem_req, trap, pc, pc_plus4, m_pc, m_pc + 32'd4);
            end
            tick();
        end
        stall      = 1'b0;
        imem_ready = 1'b0;
        if (jr)
            tgt = (rs1_v + imm_v) & 32'hFFFF_FFFE;
        else if (j || br)
            tgt = m_pc + imm_v;
        else
            tgt = m_pc + 32'd4;
        redir     = jr | j | br;
        e.trap    = redir && tgt[1];
        e.pc      = e.trap ? 32'h0000_0100 : tgt;
        m_instret = m_instret + 64'd1;
        e.instret = m_instret;
        sb_q.push_back(e);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
            errors++;
            $display("FAIL exec_retire got valid %b pc %h pc4 %h exp valid 1 pc %h pc4 %h",
                     inst_valid, pc, pc_plus4, m_pc, m_pc + 32'd4);
        end
        m_pc = e.pc;
        tick();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jalr         = 1'b0;
        imm          = 32'd0;
        rs1          = 32'd0;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        exec_instr(0, 0, 1'b0, 1'b1, 1'b0, target - m_pc, 32'd0);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (pc !== 32'h0 || pc_plus4 !== 32'h4 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
            trap !== 1'b0 || instret !== 64'd0) begin
            errors++;
            $display("FAIL reset_state got pc %h pc4 %h req %b valid %b trap %b instret %0d exp 0 4 0 0 0 0",
                     pc, pc_plus4, imem_req, inst_valid, trap, instret);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL boot_no_req got %b exp 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_fetch got req %b addr %h exp req 1 addr 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_first_instr();
        exec_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_branch();
        goto_pc(32'h100);
        exec_instr(0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
        goto_pc(32'h100);
        exec_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
    endtask

    task automatic test_jalr_priority();
        goto_pc(32'h40);
        exec_instr(0, 1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h2001);
        exec_instr(0, 0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        exec_instr(0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h301);
    endtask

    task automatic test_trap();
        goto_pc(32'h200);
        exec_instr(0, 0, 1'b1, 1'b0, 1'b0, 32'h6, 32'd0);
        exec_instr(0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1002);
        exec_instr(0, 0, 1'b0, 1'b1, 1'b0, 32'h12, 32'd0);
    endtask

    task automatic test_stall();
        exec_instr(5, 3, 1'b0, 1'b0, 1'b0, 32'h44, 32'd0);
        exec_instr(2, 2, 1'b1, 1'b0, 1'b0, 32'h44, 32'd0);
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        exec_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid_exec();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        jump       = 1'b1;
        imm        = 32'h40;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || trap !== 1'b0 || pc !== 32'h0 || instret !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_exec got req %b valid %b trap %b pc %h instret %0d exp 0 0 0 0 0",
                     imem_req, inst_valid, trap, pc, instret);
        end
        jump      = 1'b0;
        imm       = 32'd0;
        m_pc      = 32'h0;
        m_instret = 64'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL refetch_after_reset got req %b addr %h exp req 1 addr 0", imem_req, imem_addr);
        end
        exec_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_first_instr();
        test_branch();
        test_jalr_priority();
        test_trap();
        test_stall();
        test_wrap();
        test_reset_mid_exec();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch sequencer for the multi-cycle RV32I core. Holds the architectural PC, fetches one instruction at a time over a request/ready instruction-memory handshake, and selects the next PC from the branch decision produced by the branch comparator. Also handles jump targets (JAL, JALR), misaligned-target traps and the retired-instruction count. Sits directly downstream of the branch comparator and upstream of instruction memory.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- TRAP_VEC, 32'h0000_0100: PC loaded on a misaligned control-transfer target.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_ready  in  1  instruction memory has data for imem_addr this cycle.
- stall  in  1  execute stage not finished; hold the current instruction.
- branch_taken  in  1  conditional-branch decision from the branch comparator.
- jump  in  1  current instruction is JAL.
- jalr  in  1  current instruction is JALR.
- imm  in  32  sign-extended immediate of the current instruction.
- rs1  in  32  rs1 operand value, for JALR.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- pc  out  32  PC of the current instruction.
- pc_plus4  out  32  pc + 4, link value for JAL/JALR.
- inst_valid  out  1  fetched instruction is being executed.
- trap  out  1  one-cycle pulse on a misaligned-target redirect.
- instret  out  64  count of retired instructions.

## Operation
- FSM states: BOOT, FETCH, EXEC.
- BOOT: entered on reset. imem_req=0. Moves to FETCH on the next clock.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ready. On imem_ready, moves to EXEC.
- EXEC: inst_valid=1. Control inputs (branch_taken, jump, jalr, imm, rs1) are sampled only in EXEC and ignored in every other state.
  - stall=1: stay in EXEC; pc is unchanged.
  - stall=0: the instruction retires. instret increments, pc loads next_pc, state moves to FETCH.
- next_pc priority: jalr > jump > branch_taken > sequential.
  - jalr: (rs1 + imm) with bit 0 cleared.
  - jump or branch_taken: pc + imm.
  - Otherwise: pc + 4.
- All additions are 32-bit modulo 2^32; pc + 4 from 32'hFFFF_FFFC wraps to 0.
- Misaligned target: next_pc[1]=1 on a redirect (jalr, jump or branch_taken).
  - pc loads TRAP_VEC instead of the target.
  - trap pulses for one cycle, coincident with the retiring EXEC cycle.
  - instret still increments.
  - The sequential path can never trap.
- imem_ready outside FETCH is ignored.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, imem_req=0, inst_valid=0, trap=0, instret=0; pc_plus4=RESET_PC+4.
- Reset is asynchronous. Asserting rst mid-fetch or mid-EXEC immediately drops imem_req and inst_valid and discards the pending redirect.
- Minimum throughput is 2 cycles per instruction: FETCH with imem_ready=1, then EXEC with stall=0.
- After reset release, the first imem_req is asserted 1 cycle later (BOOT).
- pc, pc_plus4 and imem_addr are registered-stable for the full duration of each FETCH and EXEC. pc updates on the EXEC→FETCH edge.
- trap and inst_valid are combinational from state and inputs in EXEC. All other outputs are registered.
- instret wraps modulo 2^64.

## Structure
- Add to the shared core package riscv_pkg:
  - seq_state_t enum {BOOT, FETCH, EXEC}.
  - pc_src_t enum {PC_SEQ, PC_BR, PC_JAL, PC_JALR}.
  - Constant INSTR_BYTES = 4.
- One combinational sub-module, next_pc_gen: takes pc, imm, rs1, branch_taken, jump and jalr; produces next_pc, pc_src and misaligned.
- pc_sequencer owns the FSM, the PC register and the instret counter.

## Test plan
- Reset release, then imem_ready=1 on the first FETCH → imem_addr=0x0 at cycle 1, inst_valid at cycle 2; with stall=0, pc=0x4 at cycle 3 and instret=1.
- pc=0x100, branch_taken=1, imm=-8, stall=0 → pc=0x0F8, trap=0. Repeat with branch_taken=0 → pc=0x104.
- jump=1, jalr=1, rs1=0x2001, imm=0x10, pc=0x40 → JALR wins; pc=0x2010, pc_plus4 seen during EXEC = 0x44.
- branch_taken=1, imm=0x6, pc=0x200 → trap pulses 1 cycle, pc=TRAP_VEC=0x100, instret increments.
- Hold imem_ready=0 for 5 cycles, then stall=1 for 3 cycles in EXEC → imem_addr constant and pc unchanged throughout; branch_taken toggling during FETCH has no effect.
- Assert rst in EXEC with a pending jump → imem_req=0 and inst_valid=0 in the same cycle; pc=RESET_PC; instret=0.
